// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between the I-cache and D-cache miss paths.
// Optional perf counters are built when PMEM_ARB_PERF_EN is defined.
module pmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       d_grant_cnt,
  output logic [31:0]       i_wait_cnt
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              d_req, i_win, d_win;

  // Arbitration is only evaluated in IDLE; busy states ignore requester inputs.
  always_comb begin
    d_req = d_pmem_read | d_pmem_write;
    i_win = 1'b0;
    d_win = 1'b0;
    if (state_q == IDLE) begin
      i_win = i_pmem_read & (~d_req | (starve_cnt_q == STARVE_MAX));
      d_win = d_req & ~i_win;
    end
  end

  always_comb begin
    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (i_win) begin
          state_d        = I_BUSY;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = i_pmem_address;
          pmem_wdata_d   = '0;
        end else if (d_win) begin
          state_d        = D_BUSY;
          pmem_read_d    = d_pmem_read & ~d_pmem_write;  // write wins an illegal read+write
          pmem_write_d   = d_pmem_write;
          pmem_address_d = d_pmem_address;
          pmem_wdata_d   = d_pmem_wdata;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase

    starve_cnt_d = starve_cnt_q;
    if (!i_pmem_read || i_win) begin
      starve_cnt_d = '0;
    end else if (d_win && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      starve_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Responses route combinationally to the owner only; the other side sees zeros.
  assign i_pmem_resp  = (state_q == I_BUSY) & pmem_resp;
  assign d_pmem_resp  = (state_q == D_BUSY) & pmem_resp;
  assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

`ifdef PMEM_ARB_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] i_grant_cnt_q, i_grant_cnt_d;
  logic [31:0] d_grant_cnt_q, d_grant_cnt_d;
  logic [31:0] i_wait_cnt_q, i_wait_cnt_d;

  always_comb begin
    i_grant_cnt_d = sat_inc32(i_grant_cnt_q, i_win);
    d_grant_cnt_d = sat_inc32(d_grant_cnt_q, d_win);
    i_wait_cnt_d  = sat_inc32(i_wait_cnt_q, i_pmem_read & (state_q != I_BUSY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grant_cnt_q <= '0;
      d_grant_cnt_q <= '0;
      i_wait_cnt_q  <= '0;
    end else begin
      i_grant_cnt_q <= i_grant_cnt_d;
      d_grant_cnt_q <= d_grant_cnt_d;
      i_wait_cnt_q  <= i_wait_cnt_d;
    end
  end

  assign i_grant_cnt = i_grant_cnt_q;
  assign d_grant_cnt = d_grant_cnt_q;
  assign i_wait_cnt  = i_wait_cnt_q;
`else
  assign i_grant_cnt = 32'h0;
  assign d_grant_cnt = 32'h0;
  assign i_wait_cnt  = 32'h0;
`endif

endmodule
